// File: rtl/xorpuf_eval_ctrl.sv
// xorpuf_eval_ctrl: sequences one XOR arbiter-PUF evaluation per accepted challenge.
// Latency: the response is valid S+1+REPS*(2S+1) cycles after the accept cycle (S = SETTLE_CYC).
// Backpressure: req_ready is low while busy, and the response is held in DONE until rsp_ready.
//
// The challenge is registered onto puf_chal. The race edge puf_launch goes low (PRE), then
// high (RISE), is sampled once (SAMPLE), and goes low again (FALL), REPS times in total.
// arb_out is asynchronous to the launch, so it passes through a 2-flop synchronizer first.
// rsp_raw holds the per-chain result and rsp_bit is its XOR.
//
// Optional feature macro: XORPUF_MAJVOTE_EN
//   undefined : REPS = 1, and rsp_raw is the single SAMPLE capture.
//   defined   : REPS = VOTE_N. Each chain counts its 1s, and rsp_raw[i] = (count > VOTE_N/2).
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   req_valid/req_ready/req_chal   challenge request handshake
//   rsp_valid/rsp_ready            response handshake
//   rsp_bit, rsp_raw               XORed response and the per-chain bits
//   puf_chal, puf_launch           drive to the PUF chains
//   arb_out                        arbiter outputs (asynchronous)
//   busy                           high in any state other than IDLE

module xorpuf_eval_ctrl #(
    parameter int CHAL_W     = 64,
    parameter int N_PUF      = 4,
    parameter int SETTLE_CYC = 16,
    parameter int VOTE_N     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CHAL_W-1:0] req_chal,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_bit,
    output logic [N_PUF-1:0]  rsp_raw,
    output logic [CHAL_W-1:0] puf_chal,
    output logic              puf_launch,
    input  logic [N_PUF-1:0]  arb_out,
    output logic              busy
);

`ifdef XORPUF_MAJVOTE_EN
    localparam int REPS = VOTE_N;
`else
    localparam int REPS = 1;
`endif

    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE_CYC - 1);
    localparam logic [3:0] LAST_REP  = 4'(REPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_RISE,
        S_SAMPLE,
        S_FALL,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [7:0]          r_cnt;
    logic [3:0]          r_rep;
    logic                r_req_ready;
    logic                r_launch;
    logic                r_rsp_valid;
    logic                r_rsp_bit;
    logic [N_PUF-1:0]    r_rsp_raw;
    logic [CHAL_W-1:0]   r_chal;
    logic [N_PUF-1:0]    r_sync1;
    logic [N_PUF-1:0]    r_sync2;
    logic [N_PUF-1:0]    w_final;
    logic                w_accept;

    assign w_accept = (r_state == S_IDLE) && req_valid && r_req_ready;

    // Two-flop synchronizer. Only r_sync2 is sampled by the vote or capture logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= arb_out;
            r_sync2 <= r_sync1;
        end
    end

`ifdef XORPUF_MAJVOTE_EN
    localparam int               CNT_W = $clog2(VOTE_N + 1);
    localparam logic [CNT_W-1:0] HALF  = CNT_W'(VOTE_N / 2);

    logic [CNT_W-1:0] r_vote [N_PUF];

    // Per-chain ones counters. They are cleared on accept, so the votes of an aborted
    // challenge never carry over to the next one.
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            for (int i = 0; i < N_PUF; i++) begin
                r_vote[i] <= '0;
            end
        end else if (r_state == S_SAMPLE) begin
            for (int i = 0; i < N_PUF; i++) begin
                if (r_sync2[i]) begin
                    r_vote[i] <= r_vote[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_final = '0;
        for (int i = 0; i < N_PUF; i++) begin
            w_final[i] = (r_vote[i] > HALF);
        end
    end
`else
    logic [N_PUF-1:0] r_samp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_samp <= '0;
        end else if (r_state == S_SAMPLE) begin
            r_samp <= r_sync2;
        end
    end

    assign w_final = r_samp;
`endif

    // Sequencer. All outputs are registered. Each timed state lasts SETTLE_CYC cycles,
    // and r_cnt is reloaded with SETTLE_CYC-1 whenever one of those states is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rep       <= '0;
            r_req_ready <= 1'b0;
            r_launch    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_bit   <= 1'b0;
            r_rsp_raw   <= '0;
            r_chal      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_chal      <= req_chal;
                        r_rep       <= '0;
                        r_cnt       <= SETTLE_M1;
                        r_req_ready <= 1'b0;
                        r_state     <= S_PRE;
                    end
                end
                S_PRE: begin
                    if (r_cnt == 8'd0) begin
                        r_cnt    <= SETTLE_M1;
                        r_launch <= 1'b1;
                        r_state  <= S_RISE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_RISE: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_SAMPLE: begin
                    r_launch <= 1'b0;
                    r_cnt    <= SETTLE_M1;
                    r_state  <= S_FALL;
                end
                S_FALL: begin
                    if (r_cnt == 8'd0) begin
                        if (r_rep != LAST_REP) begin
                            r_rep    <= r_rep + 4'd1;
                            r_cnt    <= SETTLE_M1;
                            r_launch <= 1'b1;
                            r_state  <= S_RISE;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_raw   <= w_final;
                            r_rsp_bit   <= ^w_final;
                            r_state     <= S_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_DONE: begin
                    // IDLE is entered with req_ready already high, so the next accept can
                    // happen one cycle after the response handshake and never in the same cycle.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_launch    <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_bit    = r_rsp_bit;
    assign rsp_raw    = r_rsp_raw;
    assign puf_chal   = r_chal;
    assign puf_launch = r_launch;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_xorpuf_eval_ctrl.sv
// Bench for xorpuf_eval_ctrl: random challenges and arbiter values checked against a
// majority and XOR reference model. It also checks the cycle positions of the launch and
// the response, and covers backpressure, requests made while busy, and reset mid-RISE.
module tb_xorpuf_eval_ctrl;
    localparam int CHAL_W = 64;
    localparam int N_PUF  = 4;
    localparam int S      = 16;
    localparam int VOTE_N = 5;
`ifdef XORPUF_MAJVOTE_EN
    localparam int REPS = VOTE_N;
`else
    localparam int REPS = 1;
`endif

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [CHAL_W-1:0] req_chal;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_bit;
    logic [N_PUF-1:0]  rsp_raw;
    logic [CHAL_W-1:0] puf_chal;
    logic              puf_launch;
    logic [N_PUF-1:0]  arb_out;
    logic              busy;

    xorpuf_eval_ctrl #(
        .CHAL_W(CHAL_W), .N_PUF(N_PUF), .SETTLE_CYC(S), .VOTE_N(VOTE_N)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_chal(req_chal),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_bit(rsp_bit), .rsp_raw(rsp_raw),
        .puf_chal(puf_chal), .puf_launch(puf_launch),
        .arb_out(arb_out), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [N_PUF-1:0] pat [16];
    bit               use_pat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Each chain's bit is 1 when more than half of the evaluations sampled it as 1.
    function automatic logic [N_PUF-1:0] model_raw(input logic [N_PUF-1:0] v[$]);
        logic [N_PUF-1:0] r;
        r = '0;
        for (int i = 0; i < N_PUF; i++) begin
            int ones;
            ones = 0;
            foreach (v[k]) ones += int'(v[k][i]);
            r[i] = (2 * ones > v.size());
        end
        return r;
    endfunction

    task automatic wait_ready();
        int w;
        w = 0;
        while (!req_ready && w < 20) begin
            tick();
            w++;
        end
        check("ready_before_req", 64'(req_ready), 64'd1);
    endtask

    // One full transaction. Cycle 0 is the accept cycle, and the value seen 1 ns after the
    // k-th edge following it belongs to cycle k.
    task automatic run_txn(input logic [CHAL_W-1:0] chal, input int bp, input bit poke);
        int               cyc;
        int               launch_cyc;
        int               rsp_cyc;
        logic             prev_launch;
        logic [N_PUF-1:0] vals[$];
        logic [N_PUF-1:0] v;
        logic [N_PUF-1:0] exp;
        bit               chal_bad;
        bit               bad;

        wait_ready();
        req_chal  = chal;
        req_valid = 1'b1;
        tick();
        req_valid   = 1'b0;
        req_chal    = ~chal;
        cyc         = 1;
        launch_cyc  = -1;
        rsp_cyc     = -1;
        prev_launch = 1'b0;
        chal_bad    = 1'b0;
        while (cyc < 400) begin
            if (puf_chal !== chal) chal_bad = 1'b1;
            if (puf_launch && !prev_launch) begin
                if (launch_cyc < 0) launch_cyc = cyc;
                v = use_pat ? pat[vals.size()] : N_PUF'($urandom);
                vals.push_back(v);
                arb_out = v;
            end
            prev_launch = puf_launch;
            if (rsp_valid) begin
                rsp_cyc = cyc;
                break;
            end
            if (poke && cyc == 10) begin
                check("ready_while_busy", 64'(req_ready), 64'd0);
                req_valid = 1'b1;
                req_chal  = ~chal;
            end else begin
                req_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        req_valid = 1'b0;
        check("launch_cycle", 64'(launch_cyc), 64'(S + 1));
        check("rsp_cycle", 64'(rsp_cyc), 64'(S + 1 + REPS * (2 * S + 1)));
        check("launch_count", 64'(vals.size()), 64'(REPS));
        check("chal_hold", 64'(chal_bad), 64'd0);
        exp = model_raw(vals);
        check("rsp_raw", 64'(rsp_raw), 64'(exp));
        check("rsp_bit", 64'(rsp_bit), 64'(^exp));
        check("ready_in_done", 64'(req_ready), 64'd0);
        bad = 1'b0;
        for (int i = 0; i < bp; i++) begin
            tick();
            if (!rsp_valid || rsp_raw !== exp || rsp_bit !== ^exp || puf_launch
                || req_ready || !busy || puf_chal !== chal) bad = 1'b1;
        end
        if (bp > 0) check("backpressure_stable", 64'(bad), 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_drop", 64'(rsp_valid), 64'd0);
        check("idle_ready", 64'(req_ready), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_chal  = '0;
        rsp_ready = 1'b0;
        arb_out   = '0;
        use_pat   = 1'b0;
        for (int i = 0; i < 16; i++) pat[i] = '0;
        repeat (3) tick();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_launch", 64'(puf_launch), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_raw", 64'(rsp_raw), 64'd0);
        check("rst_rsp_bit", 64'(rsp_bit), 64'd0);
        check("rst_puf_chal", puf_chal, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        // Directed: constant 4'b1011 from the arbiters, the spec challenge, a poke while
        // busy, and 20 cycles of backpressure.
        use_pat = 1'b1;
        for (int i = 0; i < 16; i++) pat[i] = 4'b1011;
        run_txn(64'hDEADBEEF_0123_4567, 20, 1'b1);
        check("basic_raw_const", 64'(rsp_raw), 64'hB);
        check("basic_bit_const", 64'(rsp_bit), 64'd1);

`ifdef XORPUF_MAJVOTE_EN
        pat[0] = 4'b0001; pat[1] = 4'b0000; pat[2] = 4'b0001;
        pat[3] = 4'b0001; pat[4] = 4'b0000;
        run_txn({$urandom, $urandom}, 0, 1'b0);
        check("vote_raw_const", 64'(rsp_raw), 64'h1);
`endif

        use_pat = 1'b0;
        repeat (4) run_txn({$urandom, $urandom}, int'($urandom_range(0, 5)), 1'b0);

        // Reset during RISE at cycle 20: the challenge is aborted and no response follows.
        wait_ready();
        req_chal  = {$urandom, $urandom};
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (19) tick();
        check("pre_abort_launch", 64'(puf_launch), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_launch", 64'(puf_launch), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 250; i++) begin
            if (rsp_valid) seen = 1'b1;
            tick();
        end
        check("abort_no_rsp", 64'(seen), 64'd0);
        run_txn({$urandom, $urandom}, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
